// File: rtl/cpu_alu_pkg.sv
// Shared Flare32 CPU definitions used by the ALU, decoder and branch unit.
//   CPU_WORD_WIDTH : native operand/result width
//   EnumAluOper    : 4-bit ALU operation code
//   EnumFlagsPos   : bit positions of Z, C, V, N inside a 4-bit flags word
//   StrcInAlu      : {a_in, b_in, oper, flags_in} at the native width
//   StrcOutAlu     : {out, flags_out} at the native width
package pkg_cpu;

  localparam int unsigned CPU_WORD_WIDTH = 32;

  typedef enum logic [3:0] {
    AluAdd = 4'd0,
    AluAdc = 4'd1,
    AluSub = 4'd2,
    AluSbc = 4'd3,
    AluRsb = 4'd4,
    AluMul = 4'd5,
    AluAnd = 4'd6,
    AluOrr = 4'd7,
    AluXor = 4'd8,
    AluLsl = 4'd9,
    AluLsr = 4'd10,
    AluAsr = 4'd11,
    AluRol = 4'd12,
    AluRor = 4'd13,
    AluCpy = 4'd14,
    AluNot = 4'd15
  } EnumAluOper;

  typedef enum logic [1:0] {
    FlagZ = 2'd0,
    FlagC = 2'd1,
    FlagV = 2'd2,
    FlagN = 2'd3
  } EnumFlagsPos;

  typedef struct packed {
    logic [CPU_WORD_WIDTH-1:0] a_in;
    logic [CPU_WORD_WIDTH-1:0] b_in;
    EnumAluOper                oper;
    logic [3:0]                flags_in;
  } StrcInAlu;

  typedef struct packed {
    logic [CPU_WORD_WIDTH-1:0] out;
    logic [3:0]                flags_out;
  } StrcOutAlu;

endpackage

// File: rtl/cpu_alu_shifter.sv
// Barrel shifter / rotator for the ALU.
//   a_in   : value to shift
//   amt    : shift amount, already reduced modulo WORD_WIDTH
//   oper   : AluLsl / AluLsr / AluAsr / AluRol / AluRor (others pass a_in)
//   c_in   : carry flag passed through when amt is zero
//   result : shifted value
//   c_out  : last bit shifted or rotated out
module cpu_alu_shifter
  import pkg_cpu::*;
#(
  parameter int unsigned WORD_WIDTH = CPU_WORD_WIDTH
) (
  input  logic [WORD_WIDTH-1:0]         a_in,
  input  logic [$clog2(WORD_WIDTH)-1:0] amt,
  input  EnumAluOper                    oper,
  input  logic                          c_in,
  output logic [WORD_WIDTH-1:0]         result,
  output logic                          c_out
);

  // Extended vectors carry one guard bit so the shifted-out bit falls out
  // of the same shift that produces the result.
  logic [WORD_WIDTH:0]       lsl_ext;
  logic [WORD_WIDTH:0]       lsr_ext;
  logic [WORD_WIDTH:0]       asr_ext;
  logic [2*WORD_WIDTH-1:0]   rol_ext;
  logic [2*WORD_WIDTH-1:0]   ror_ext;

  always_comb begin
    lsl_ext = {1'b0, a_in} << amt;
    lsr_ext = {a_in, 1'b0} >> amt;
    asr_ext = $signed({a_in, 1'b0}) >>> amt;
    rol_ext = {a_in, a_in} << amt;
    ror_ext = {a_in, a_in} >> amt;

    result = a_in;
    c_out  = c_in;
    if (amt != '0) begin
      case (oper)
        AluLsl: begin
          result = lsl_ext[WORD_WIDTH-1:0];
          c_out  = lsl_ext[WORD_WIDTH];
        end
        AluLsr: begin
          result = lsr_ext[WORD_WIDTH:1];
          c_out  = lsr_ext[0];
        end
        AluAsr: begin
          result = asr_ext[WORD_WIDTH:1];
          c_out  = asr_ext[0];
        end
        AluRol: begin
          result = rol_ext[2*WORD_WIDTH-1:WORD_WIDTH];
          c_out  = rol_ext[WORD_WIDTH];
        end
        AluRor: begin
          result = ror_ext[WORD_WIDTH-1:0];
          c_out  = ror_ext[WORD_WIDTH-1];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/cpu_alu.sv
// Flare32 execute-stage integer ALU with registered result and flags.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears result and flags
//   in    : packed {a_in, b_in, oper[4], flags_in[4]} (StrcInAlu layout)
//   out   : packed {out, flags_out[4]}               (StrcOutAlu layout)
// Ports are flat vectors so WORD_WIDTH can differ from CPU_WORD_WIDTH; at the
// default width they are bit-identical to StrcInAlu / StrcOutAlu.
module cpu_alu
  import pkg_cpu::*;
#(
  parameter int unsigned WORD_WIDTH = CPU_WORD_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [2*WORD_WIDTH+7:0]   in,
  output logic [WORD_WIDTH+3:0]     out
);

  localparam int unsigned SHW = $clog2(WORD_WIDTH);

  typedef struct packed {
    logic [WORD_WIDTH-1:0] a_in;
    logic [WORD_WIDTH-1:0] b_in;
    EnumAluOper            oper;
    logic [3:0]            flags_in;
  } alu_in_t;

  typedef struct packed {
    logic [WORD_WIDTH-1:0] out;
    logic [3:0]            flags_out;
  } alu_out_t;

  alu_in_t               in_s;
  alu_out_t              out_s;

  logic [WORD_WIDTH-1:0] op_x;
  logic [WORD_WIDTH-1:0] op_y;
  logic                  op_cin;
  logic [WORD_WIDTH:0]   sum;
  logic                  arith_v;
  logic [WORD_WIDTH-1:0] prod;
  logic [WORD_WIDTH-1:0] shf_res;
  logic                  shf_c;

  logic [WORD_WIDTH-1:0] res;
  logic                  res_c;
  logic                  res_v;

  logic [WORD_WIDTH-1:0] out_d, out_q;
  logic [3:0]            flags_d, flags_q;

  assign in_s = in;

  // All five arithmetic ops share one adder: subtraction is x + ~y + 1, and
  // Sbc feeds C directly as the carry-in (C = NOT borrow).
  always_comb begin
    op_x   = in_s.a_in;
    op_y   = in_s.b_in;
    op_cin = 1'b0;
    case (in_s.oper)
      AluAdc: op_cin = in_s.flags_in[FlagC];
      AluSub: begin
        op_y   = ~in_s.b_in;
        op_cin = 1'b1;
      end
      AluSbc: begin
        op_y   = ~in_s.b_in;
        op_cin = in_s.flags_in[FlagC];
      end
      AluRsb: begin
        op_x   = in_s.b_in;
        op_y   = ~in_s.a_in;
        op_cin = 1'b1;
      end
      default: ;
    endcase
    sum     = {1'b0, op_x} + {1'b0, op_y} + {{WORD_WIDTH{1'b0}}, op_cin};
    arith_v = (op_x[WORD_WIDTH-1] == op_y[WORD_WIDTH-1]) &&
              (sum[WORD_WIDTH-1] != op_x[WORD_WIDTH-1]);
    prod    = in_s.a_in * in_s.b_in;
  end

  cpu_alu_shifter #(
    .WORD_WIDTH(WORD_WIDTH)
  ) u_shifter (
    .a_in   (in_s.a_in),
    .amt    (in_s.b_in[SHW-1:0]),
    .oper   (in_s.oper),
    .c_in   (in_s.flags_in[FlagC]),
    .result (shf_res),
    .c_out  (shf_c)
  );

  always_comb begin
    res   = '0;
    res_c = in_s.flags_in[FlagC];
    res_v = in_s.flags_in[FlagV];
    case (in_s.oper)
      AluAdd, AluAdc, AluSub, AluSbc, AluRsb: begin
        res   = sum[WORD_WIDTH-1:0];
        res_c = sum[WORD_WIDTH];
        res_v = arith_v;
      end
      AluMul: res = prod;
      AluAnd: res = in_s.a_in & in_s.b_in;
      AluOrr: res = in_s.a_in | in_s.b_in;
      AluXor: res = in_s.a_in ^ in_s.b_in;
      AluLsl, AluLsr, AluAsr, AluRol, AluRor: begin
        res   = shf_res;
        res_c = shf_c;
      end
      AluCpy: res = in_s.b_in;
      AluNot: res = ~in_s.b_in;
      default: ;
    endcase

    out_d          = res;
    flags_d        = '0;
    flags_d[FlagZ] = (res == '0);
    flags_d[FlagC] = res_c;
    flags_d[FlagV] = res_v;
    flags_d[FlagN] = res[WORD_WIDTH-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q   <= '0;
      flags_q <= '0;
    end else begin
      out_q   <= out_d;
      flags_q <= flags_d;
    end
  end

  always_comb begin
    out_s.out       = out_q;
    out_s.flags_out = flags_q;
  end

  assign out = out_s;

endmodule

// File: tb/tb_cpu_alu.sv
// Scoreboard bench for cpu_alu at WORD_WIDTH=8: directed cases, exhaustive
// Sub with compare-contract checks, random ops and reset behaviour.
module tb_cpu_alu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  a, b;
  logic [3:0]  op, fin;
  logic [23:0] in_vec;
  logic [11:0] out_vec;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          a;
    int          b;
    int          op;
    int          fin;
    logic [11:0] exp;
  } sb_t;

  sb_t q[$];

  assign in_vec = {a, b, op, fin};

  cpu_alu #(.WORD_WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .in    (in_vec),
    .out   (out_vec)
  );

  always #5 clk = ~clk;

  function automatic int sx(input int x);
    return (x >= 128) ? x - 256 : x;
  endfunction

  // Reference: plain integer arithmetic on 8-bit values; flags {N,V,C,Z}.
  function automatic logic [11:0] model(input int ai, input int bi, input int opi, input int fi);
    int   cin, bw, r, s, amt, sa, sb;
    logic c, v, n, z;
    logic [7:0] r8;
    cin = (fi >> 1) & 1;
    c   = cin[0];
    v   = fi[2];
    sa  = sx(ai);
    sb  = sx(bi);
    amt = bi % 8;
    s   = 0;
    r   = 0;
    case (opi)
      0: begin r = ai + bi;       c = (r > 255); s = sa + sb;       v = (s > 127 || s < -128); end
      1: begin r = ai + bi + cin; c = (r > 255); s = sa + sb + cin; v = (s > 127 || s < -128); end
      2: begin r = ai - bi; c = (ai >= bi); s = sa - sb; v = (s > 127 || s < -128); end
      3: begin
        bw = 1 - cin;
        r = ai - bi - bw; c = (ai >= bi + bw); s = sa - sb - bw; v = (s > 127 || s < -128);
      end
      4: begin r = bi - ai; c = (bi >= ai); s = sb - sa; v = (s > 127 || s < -128); end
      5: r = ai * bi;
      6: r = ai & bi;
      7: r = ai | bi;
      8: r = ai ^ bi;
      9:  if (amt == 0) r = ai; else begin r = ai << amt; c = ((ai >> (8 - amt)) & 1) != 0; end
      10: if (amt == 0) r = ai; else begin r = ai >> amt; c = ((ai >> (amt - 1)) & 1) != 0; end
      11: if (amt == 0) r = ai; else begin r = sa >>> amt; c = ((ai >> (amt - 1)) & 1) != 0; end
      12: if (amt == 0) r = ai; else begin
        r = (ai << amt) | (ai >> (8 - amt)); c = ((ai >> (8 - amt)) & 1) != 0;
      end
      13: if (amt == 0) r = ai; else begin
        r = (ai >> amt) | (ai << (8 - amt)); c = ((ai >> (amt - 1)) & 1) != 0;
      end
      14: r = bi;
      default: r = ~bi;
    endcase
    r8 = r[7:0];
    n  = r8[7];
    z  = (r8 == 8'h00);
    return {r8, n, v, c, z};
  endfunction

  task automatic drive_push(input int ai, input int bi, input int opi, input int fi);
    sb_t e;
    a   = 8'(ai);
    b   = 8'(bi);
    op  = 4'(opi);
    fin = 4'(fi);
    e.a = ai; e.b = bi; e.op = opi; e.fin = fi;
    e.exp = model(ai, bi, opi, fi);
    q.push_back(e);
  endtask

  task automatic issue(input int ai, input int bi, input int opi, input int fi);
    @(negedge clk);
    drive_push(ai, bi, opi, fi);
  endtask

  task automatic check_zero(input string name);
    checks++;
    if (out_vec !== 12'h000) begin
      errors++;
      $display("FAIL %s got=%h exp=000", name, out_vec);
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 10 && q.size() > 0; k++) @(posedge clk);
    #2;
  endtask

  // Monitor: output is valid every cycle once out of reset.
  initial begin
    sb_t  e;
    logic n, v, c, z, ok;
    int   sa, sb;
    forever begin
      @(posedge clk);
      #1;
      if (rst_n && q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if (out_vec !== e.exp) begin
          errors++;
          $display("FAIL result op=%0d a=%02h b=%02h fin=%h got=%h exp=%h",
                   e.op, e.a[7:0], e.b[7:0], e.fin[3:0], out_vec, e.exp);
        end
        if (e.op == 2) begin
          n = out_vec[3]; v = out_vec[2]; c = out_vec[1]; z = out_vec[0];
          sa = sx(e.a);
          sb = sx(e.b);
          ok = (z == (e.a == e.b)) &&
               ((!c) == (e.a < e.b)) && (c == (e.a >= e.b)) &&
               ((c && !z) == (e.a > e.b)) && ((!c || z) == (e.a <= e.b)) &&
               ((n != v) == (sa < sb)) && ((n == v) == (sa >= sb)) &&
               ((n == v && !z) == (sa > sb)) && (((n != v) || z) == (sa <= sb));
          checks++;
          if (!ok) begin
            errors++;
            $display("FAIL compare_contract a=%02h b=%02h got_flags=%b exp_flags=%b",
                     e.a[7:0], e.b[7:0], out_vec[3:0], e.exp[3:0]);
          end
        end
      end
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    a = '0; b = '0; op = '0; fin = '0;
    #2;
    check_zero("reset_state");
    a = 8'h12; b = 8'h34; op = 4'd0;
    #20;
    check_zero("reset_held_over_edges");
    @(negedge clk);
    rst_n = 1'b1;

    // Directed cases
    issue(8'h05, 8'h05, 2, 0);
    issue(8'h03, 8'h05, 2, 0);
    issue(8'h80, 8'h01, 2, 0);
    issue(8'h42, 8'h00, 2, 4'hF);
    issue(8'hFF, 8'h01, 0, 0);
    issue(8'h7F, 8'h00, 1, 4'b0010);
    issue(8'h10, 8'h20, 3, 4'b0000);
    issue(8'h10, 8'h20, 4, 4'b1101);
    issue(8'h81, 8'h01, 10, 0);
    issue(8'h81, 8'h00, 9, 4'b0010);
    issue(8'h81, 8'h08, 9, 4'b0000);
    issue(8'h80, 8'h07, 11, 4'b0010);
    issue(8'h01, 8'h01, 13, 0);
    issue(8'h81, 8'h03, 12, 0);
    issue(8'h0F, 8'hF0, 15, 4'b0110);
    issue(8'hAA, 8'h55, 14, 4'b0100);

    // Exhaustive Sub with random, unused flags_in
    for (int i = 0; i < 256; i++)
      for (int j = 0; j < 256; j++)
        issue(i, j, 2, $urandom_range(0, 15));

    // Random mix of every opcode
    for (int k = 0; k < 2000; k++)
      issue($urandom_range(0, 255), $urandom_range(0, 255),
            $urandom_range(0, 15), $urandom_range(0, 15));

    drain();

    // Reset between edges discards the in-flight result
    issue(8'h10, 8'h10, 5, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_zero("async_reset_midcycle");
    @(posedge clk);
    #1;
    check_zero("reset_over_edge");
    @(negedge clk);
    rst_n = 1'b1;
    drive_push(3, 4, 0, 0);
    drain();

    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got=%0d exp=0", q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
